// File: rtl/fft_stream_checker.sv
// Stimulus driver and answer-stream checker for serial N-point FFT cores.
// Plays N samples, then checks 2N answer words against golden memory with LSB tolerance and timeout.
module fft_stream_checker #(
  parameter int N_POINTS = 32,
  parameter int IN_W     = 11,
  parameter int OUT_W    = 17,
  parameter int TOL      = 0,
  parameter int TIMEOUT  = 150,
  parameter int AW       = $clog2(2*N_POINTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mem_we,
  input  logic             mem_sel,
  input  logic [AW-1:0]    mem_addr,
  input  logic [OUT_W-1:0] mem_wdata,
  output logic             valid_o,
  output logic [IN_W-1:0]  x_o,
  input  logic             finish_i,
  input  logic [OUT_W-1:0] answer_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [AW:0]      err_cnt,
  output logic [AW-1:0]    first_err_idx,
  output logic             first_err_valid
);

  localparam int NW = 2*N_POINTS;
  localparam int SW = (N_POINTS > 1) ? $clog2(N_POINTS) : 1;
  localparam int CW = $clog2(TIMEOUT+1);

  typedef enum logic [1:0] {IDLE, DRIVE, COLLECT, DONE} state_t;

  state_t state, state_nxt;

  logic [IN_W-1:0]  stim_mem [N_POINTS];
  logic [OUT_W-1:0] gold_mem [NW];

  logic [AW-1:0] k;
  logic [AW:0]   j;
  logic [CW-1:0] cyc;

  logic            idle_like, active, accept, mismatch, last, cyc_hit, drive_end;
  logic [AW-1:0]   rd_k;
  logic [IN_W-1:0] stim_q;
  logic [OUT_W-1:0] gold_q;
  logic [OUT_W:0]  diff, mag;
  logic [AW:0]     err_nxt;

  logic            valid_d, busy_d, done_d, pass_d, timeout_d;
  logic [IN_W-1:0] x_d;

  // Memories keep their contents across reset; writes only while not running.
  always_ff @(posedge clk) begin
    if (mem_we && idle_like) begin
      if (!mem_sel) begin
        if (mem_addr < AW'(N_POINTS)) stim_mem[SW'(mem_addr)] <= mem_wdata[IN_W-1:0];
      end else if ({1'b0, mem_addr} < (AW+1)'(NW)) begin
        gold_mem[mem_addr] <= mem_wdata;
      end
    end
  end

  always_comb begin
    idle_like = (state == IDLE) || (state == DONE);
    active    = (state == DRIVE) || (state == COLLECT);
    drive_end = (k == AW'(N_POINTS));
    rd_k      = (state == DRIVE) ? k : '0;
    stim_q    = stim_mem[SW'(rd_k)];
    gold_q    = gold_mem[j[AW-1:0]];
    accept    = active && finish_i && (j < (AW+1)'(NW));
    last      = accept && (j == (AW+1)'(NW-1));
    // Sign-extend by one bit so the difference never overflows.
    diff      = {answer_i[OUT_W-1], answer_i} - {gold_q[OUT_W-1], gold_q};
    mag       = diff[OUT_W] ? -diff : diff;
    mismatch  = accept && (mag > (OUT_W+1)'(TOL));
    err_nxt   = err_cnt + (AW+1)'(mismatch);
    cyc_hit   = active && (cyc == CW'(TIMEOUT-1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (start) state_nxt = DRIVE;
      DRIVE: begin
        if (last || cyc_hit) state_nxt = DONE;
        else if (drive_end)  state_nxt = COLLECT;
      end
      COLLECT: if (last || cyc_hit) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    valid_d   = valid_o;
    x_d       = x_o;
    busy_d    = busy;
    done_d    = done;
    pass_d    = pass;
    timeout_d = timeout;
    if (idle_like) begin
      if (start) begin
        valid_d   = 1'b1;
        x_d       = stim_q;
        busy_d    = 1'b1;
        done_d    = 1'b0;
        pass_d    = 1'b0;
        timeout_d = 1'b0;
      end
    end else begin
      if (state == DRIVE && !drive_end) begin
        valid_d = 1'b1;
        x_d     = stim_q;
      end else begin
        valid_d = 1'b0;
        x_d     = '0;
      end
      // A last word on the timeout cycle takes priority over the timeout.
      if (state_nxt == DONE) begin
        valid_d   = 1'b0;
        x_d       = '0;
        busy_d    = 1'b0;
        done_d    = 1'b1;
        pass_d    = last && (err_nxt == '0);
        timeout_d = !last;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_o         <= 1'b0;
      x_o             <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      timeout         <= 1'b0;
      err_cnt         <= '0;
      first_err_idx   <= '0;
      first_err_valid <= 1'b0;
      k               <= '0;
      j               <= '0;
      cyc             <= '0;
    end else begin
      valid_o <= valid_d;
      x_o     <= x_d;
      busy    <= busy_d;
      done    <= done_d;
      pass    <= pass_d;
      timeout <= timeout_d;
      if (idle_like) begin
        if (start) begin
          err_cnt         <= '0;
          first_err_idx   <= '0;
          first_err_valid <= 1'b0;
          k               <= AW'(1);
          j               <= '0;
          cyc             <= '0;
        end
      end else begin
        cyc <= cyc + CW'(1);
        if (state == DRIVE && !drive_end) k <= k + AW'(1);
        if (accept) begin
          j       <= j + (AW+1)'(1);
          err_cnt <= err_nxt;
          if (mismatch && !first_err_valid) begin
            first_err_idx   <= j[AW-1:0];
            first_err_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_stream_checker.sv
// Self-checking bench for fft_stream_checker: two instances (TOL=0, TOL=1) share all inputs
// and are compared against a run-level model of drive, checking and timeout rules.
module tb_fft_stream_checker;

  localparam int N     = 32;
  localparam int NW    = 64;
  localparam int IN_W  = 11;
  localparam int OUT_W = 17;
  localparam int TMO   = 150;
  localparam int AW    = 6;

  logic clk = 1'b0;
  logic rst, start, mem_we, mem_sel, finish_i;
  logic [AW-1:0]    mem_addr;
  logic [OUT_W-1:0] mem_wdata, answer_i;

  logic valid0, busy0, done0, pass0, tmo0, fval0;
  logic valid1, busy1, done1, pass1, tmo1, fval1;
  logic [IN_W-1:0] x0, x1;
  logic [AW:0]     err0, err1;
  logic [AW-1:0]   fidx0, fidx1;

  fft_stream_checker #(.N_POINTS(N), .IN_W(IN_W), .OUT_W(OUT_W), .TOL(0), .TIMEOUT(TMO), .AW(AW)) dut0 (
    .clk(clk), .rst(rst), .start(start), .mem_we(mem_we), .mem_sel(mem_sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .valid_o(valid0), .x_o(x0),
    .finish_i(finish_i), .answer_i(answer_i), .busy(busy0), .done(done0), .pass(pass0),
    .timeout(tmo0), .err_cnt(err0), .first_err_idx(fidx0), .first_err_valid(fval0));

  fft_stream_checker #(.N_POINTS(N), .IN_W(IN_W), .OUT_W(OUT_W), .TOL(1), .TIMEOUT(TMO), .AW(AW)) dut1 (
    .clk(clk), .rst(rst), .start(start), .mem_we(mem_we), .mem_sel(mem_sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .valid_o(valid1), .x_o(x1),
    .finish_i(finish_i), .answer_i(answer_i), .busy(busy1), .done(done1), .pass(pass1),
    .timeout(tmo1), .err_cnt(err1), .first_err_idx(fidx1), .first_err_valid(fval1));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [IN_W-1:0]  stim_m [N];
  logic [OUT_W-1:0] gold_m [NW];
  logic [OUT_W-1:0] ans    [80];
  int               fcyc   [80];
  int               npulse;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sx(input logic [OUT_W-1:0] v);
    return int'($signed(v));
  endfunction

  task automatic write_mem(input logic sel, input int addr, input logic [OUT_W-1:0] data);
    @(negedge clk);
    mem_we = 1'b1; mem_sel = sel; mem_addr = AW'(addr); mem_wdata = data;
    @(negedge clk);
    mem_we = 1'b0;
    if (!sel) begin
      if (addr < N) stim_m[addr] = data[IN_W-1:0];
    end else begin
      gold_m[addr] = data;
    end
  endtask

  task automatic set_sched(input int first, input int n, input int period);
    npulse = n;
    for (int w = 0; w < n; w++) fcyc[w] = first + w*period;
  endtask

  task automatic ans_ok();
    for (int w = 0; w < 80; w++) ans[w] = (w < NW) ? gold_m[w] : OUT_W'($urandom);
  endtask

  // Run-level model: completion iff all 2N words arrive by cycle TMO; words after the end are ignored.
  task automatic do_run(input string name, input int inj);
    int comp, endc, p, e0, e1, f0, f1;
    bit fv0, fv1;
    logic [11:0] vx_exp;
    comp = (npulse >= NW) && (fcyc[NW-1] <= TMO);
    endc = comp ? fcyc[NW-1] : TMO;
    e0 = 0; e1 = 0; f0 = 0; f1 = 0; fv0 = 0; fv1 = 0;
    for (int w = 0; w < NW && w < npulse; w++) begin
      if (fcyc[w] <= endc) begin
        int d;
        d = sx(ans[w]) - sx(gold_m[w]);
        if (d < 0) d = -d;
        if (d > 0) begin e0++; if (!fv0) begin fv0 = 1; f0 = w; end end
        if (d > 1) begin e1++; if (!fv1) begin fv1 = 1; f1 = w; end end
      end
    end
    @(negedge clk);
    start = 1'b1;
    p = 0;
    for (int t = 1; t <= endc + 4; t++) begin
      @(negedge clk);
      start = 1'b0;
      mem_we = 1'b0;
      vx_exp = '0;
      if (t <= N && t <= endc) vx_exp = {1'b1, stim_m[t-1]};
      check({name, "/valid_x"}, {valid0, x0}, vx_exp);
      check({name, "/busy_done0"}, {busy0, done0}, {t <= endc, t > endc});
      check({name, "/busy_done1"}, {busy1, done1}, {t <= endc, t > endc});
      if (t == endc + 1 || t == endc + 4) begin
        check({name, "/err0"}, err0, e0);
        check({name, "/fidx0"}, {fval0, fidx0}, {fv0, AW'(f0)});
        check({name, "/pass0"}, {pass0, tmo0}, {comp && e0 == 0, !comp});
        check({name, "/err1"}, err1, e1);
        check({name, "/fidx1"}, {fval1, fidx1}, {fv1, AW'(f1)});
        check({name, "/pass1"}, {pass1, tmo1}, {comp && e1 == 0, !comp});
      end
      if (t == inj) begin
        start = 1'b1; mem_we = 1'b1; mem_sel = 1'b1; mem_addr = '0; mem_wdata = 17'd7;
      end
      if (p < npulse && fcyc[p] == t) begin
        finish_i = 1'b1; answer_i = ans[p]; p++;
      end else begin
        finish_i = 1'b0; answer_i = OUT_W'($urandom);
      end
    end
    @(negedge clk);
    finish_i = 1'b0;
    start = 1'b0;
    mem_we = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; mem_we = 1'b0; mem_sel = 1'b0; mem_addr = '0;
    mem_wdata = '0; finish_i = 1'b0; answer_i = '0;
    repeat (3) @(negedge clk);
    check("reset/outs", {valid0, x0, busy0, done0, pass0, tmo0}, '0);
    check("reset/errs", {err0, fidx0, fval0}, '0);
    rst = 1'b0;

    // Ramp stimulus and golden; stimulus address beyond N must not alias into the table.
    for (int i = 0; i < N; i++) write_mem(1'b0, i, OUT_W'(i));
    for (int i = 0; i < NW; i++) write_mem(1'b1, i, OUT_W'(i));
    write_mem(1'b0, 40, 17'h3FF);

    ans_ok(); set_sched(40, 64, 1);
    do_run("ramp", 0);

    ans[40] = gold_m[40] + 17'd1;
    do_run("plus1", 0);
    ans[40] = gold_m[40] - 17'd2;
    do_run("minus2", 0);

    write_mem(1'b1, 5, 17'h1FFFB);
    ans_ok(); ans[5] = 17'h1FFFC;
    do_run("neg", 0);

    ans_ok(); set_sched(40, 63, 1);
    do_run("short63", 0);
    set_sched(87, 64, 1);
    do_run("last150", 0);
    set_sched(88, 64, 1);
    do_run("last151", 0);

    // Gaps every third cycle during DRIVE, an extra word, plus start/mem_we while busy.
    npulse = 65;
    for (int w = 0; w < 65; w++) fcyc[w] = (w < 20) ? 2 + 3*w : 59 + (w - 19);
    do_run("gaps", 5);
    set_sched(10, 64, 1);
    do_run("after_busy_we", 0);
    write_mem(1'b1, 0, 17'd7);
    do_run("gold0_written", 0);
    write_mem(1'b1, 0, 17'd0);

    // Asynchronous reset in the middle of DRIVE, with mismatches already counted.
    @(negedge clk);
    start = 1'b1;
    for (int t = 1; t <= 11; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (t == 11) begin
        check("midrst/x10", {valid0, x0}, {1'b1, stim_m[10]});
        check("midrst/err_before", err0, 9);
        finish_i = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst/valid", valid0, 0);
        check("midrst/busy", busy0, 0);
        check("midrst/err", err0, 0);
      end else if (t >= 2) begin
        finish_i = 1'b1; answer_i = gold_m[t-2] + 17'd5;
      end
    end
    @(negedge clk);
    rst = 1'b0;
    ans_ok(); set_sched(3, 64, 1);
    do_run("after_rst", 0);

    // Randomized runs: random memories, perturbed answers, random gaps and pulse counts.
    for (int it = 0; it < 6; it++) begin
      int t;
      for (int i = 0; i < N; i++) write_mem(1'b0, i, OUT_W'($urandom));
      for (int i = 0; i < NW; i++) write_mem(1'b1, i, OUT_W'($urandom));
      ans_ok();
      for (int w = 0; w < NW; w++) begin
        case ($urandom_range(0, 9))
          0: ans[w] = gold_m[w] + 17'd1;
          1: ans[w] = gold_m[w] - 17'd1;
          2: ans[w] = gold_m[w] + 17'd2;
          3: ans[w] = OUT_W'($urandom);
          default: ans[w] = gold_m[w];
        endcase
      end
      npulse = $urandom_range(63, 65);
      t = $urandom_range(1, 50);
      for (int w = 0; w < npulse; w++) begin
        fcyc[w] = t;
        t += ($urandom_range(0, 3) == 0) ? $urandom_range(2, 3) : 1;
      end
      do_run($sformatf("rand%0d", it), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_stream_checker.md
Name: fft_stream_checker

Overview:
- Synthesisable stimulus driver and self-checker for serial N-point FFT cores.
- Plays N input samples into the FFT's valid/x_r port, then compares the 2N-word answer stream (N real words, then N imag words) against stored golden words, with a programmable LSB tolerance and a cycle timeout.
- Used for on-FPGA regression and gate-level bring-up.
- Generalises the FFT bench's fixed 32-point, exact-match, 11/17-bit flow.

Parameters:
N_POINTS, 32, FFT size; number of input samples; 2*N_POINTS output words.
IN_W, 11, input sample width.
OUT_W, 17, answer word width (two's complement).
TOL, 0, max allowed |answer - golden| in LSBs.
TIMEOUT, 150, cycles from start to last expected output before abort.
AW, $clog2(2*N_POINTS), address/index width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  one-cycle request to begin a run.
mem_we  in  1  write strobe for stimulus/golden memories.
mem_sel  in  1  0 = stimulus memory (N x IN_W), 1 = golden memory (2N x OUT_W).
mem_addr  in  AW  write address.
mem_wdata  in  OUT_W  write data; stimulus writes use bits [IN_W-1:0].
valid_o  out  1  to FFT valid_i.
x_o  out  IN_W  to FFT x_r.
finish_i  in  1  from FFT finish; qualifies answer_i.
answer_i  in  OUT_W  from FFT answer.
busy  out  1  run in progress.
done  out  1  run ended; held until next start or rst.
pass  out  1  valid when done: no mismatches and no timeout.
timeout  out  1  valid when done: run aborted by timeout.
err_cnt  out  AW+1  mismatch count.
first_err_idx  out  AW  index of first mismatch; 0 if none.
first_err_valid  out  1  first_err_idx holds a real mismatch.

Behaviour:
- Reset (async, any time, including mid-run):
  - FSM goes to IDLE.
  - All outputs go to 0 immediately.
  - Counters clear.
  - Memory contents are retained, not reset.
- All outputs are registered.
- FSM states: IDLE, DRIVE, COLLECT, DONE.
- IDLE/DONE + start=1:
  - Enter DRIVE.
  - Clear err_cnt, first_err_*, done, pass, timeout, and the sample, output and cycle counters.
  - busy=1 from the next cycle.
- DRIVE:
  - valid_o=1 and x_o=stim[k] for k=0..N-1 on N consecutive cycles.
  - The first sample appears on the cycle after start is sampled.
  - After sample N-1, enter COLLECT; valid_o=0 and x_o=0.
- Checking is active in both DRIVE and COLLECT, so finish_i may assert before DRIVE ends.
- On each cycle with finish_i=1:
  - Compare answer_i to golden[j] for j = 0..2N-1, in order.
  - Gaps between finish_i pulses are allowed.
- Comparison:
  - diff = signed(answer_i) - signed(golden[j]), computed at OUT_W+1 bits with no overflow.
  - Mismatch when |diff| > TOL.
  - On mismatch: err_cnt increments.
  - On the first mismatch: first_err_idx=j and first_err_valid=1.
- After word j=2N-1 is accepted:
  - Next cycle: done=1, busy=0, pass=(err_cnt_final==0), state DONE.
  - pass must include a mismatch on that last word.
- Timeout:
  - A cycle counter runs from the first DRIVE cycle.
  - If it reaches TIMEOUT before all 2N words are accepted: done=1, timeout=1, pass=0, busy=0.
  - err_cnt and first_err_* freeze.
  - If the last word arrives on the same cycle the counter reaches TIMEOUT, the word wins: the run completes normally and timeout=0.
- Ignored inputs:
  - finish_i in IDLE or DONE, and any finish_i beyond 2N words.
  - start while busy.
  - mem_we while busy (no write occurs).
  - mem_we with mem_sel=0 and mem_addr>=N.
- Writes in IDLE/DONE take effect on the next cycle; the memories are single write-port, single read-port.
- In DONE, a new start re-runs using the same memories.

Test Plan:
- Load ramp stimulus 0..31 and golden g[j]=j; start; bench returns answer=j on 64 consecutive finish pulses from cycle 40 -> valid_o high exactly 32 cycles with x_o=0..31; done=1, pass=1, err_cnt=0, timeout=0 one cycle after the 64th pulse.
- Same run with answer[40]=g[40]+1, TOL=0 -> err_cnt=1, first_err_idx=40, first_err_valid=1, pass=0. Rerun with TOL=1 -> pass=1. Rerun with answer[40]=g[40]-2, TOL=1 -> err_cnt=1. Negative golden -5 vs answer -4 -> mismatch at TOL=0 only.
- Only 63 finish pulses, TIMEOUT=150 -> done=1, timeout=1, pass=0 exactly 150 cycles after the first DRIVE cycle. Last word on cycle 150 -> timeout=0, pass=1.
- finish_i pulses every third cycle, and starting during DRIVE -> all 64 words checked in order; pass=1. Extra 65th pulse -> counters unchanged.
- Assert rst at sample 10 of DRIVE -> valid_o, busy and err_cnt go to 0 without a clock edge. New start -> full ramp replayed from x_o=0 using the retained memories; pass=1.
- start and mem_we (golden addr 0 := 7) while busy -> run unaffected, golden[0] unchanged. After done, mem_we is accepted and the rerun reports a mismatch at idx 0.
